// File: rtl/keypad_poller_if.sv
// keypad_poller_if
//   Bundles the keypad poller's peripheral-side and consumer-side signals.
//   The master modport is the poller. The slave modport is its environment:
//   the peripheral register port plus the CPU-side consumer.
//
//   Peripheral side:
//     keyout        poller <- peripheral  status {15'b0,ready} / data {12'bx,key}
//     statusordata  poller -> peripheral  1 = status word, 0 = data word
//     ack           poller -> peripheral  clears the peripheral ready bit
//   Consumer side:
//     enable        poller <- consumer    allows polling
//     key_data      poller -> consumer    FIFO head, 0 when empty
//     key_valid     poller -> consumer    FIFO non-empty
//     key_pop       poller <- consumer    pop the head
//     count         poller -> consumer    FIFO occupancy
//     overflow      poller -> consumer    sticky key-dropped flag
//     ovf_clr       poller <- consumer    clears overflow
interface keypad_poller_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          enable;
  logic [15:0]   keyout;
  logic          statusordata;
  logic          ack;
  logic [3:0]    key_data;
  logic          key_valid;
  logic          key_pop;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    input  enable, keyout, key_pop, ovf_clr,
    output statusordata, ack, key_data, key_valid, count, overflow
  );

  modport slave (
    output enable, keyout, key_pop, ovf_clr,
    input  statusordata, ack, key_data, key_valid, count, overflow
  );
endinterface

// File: rtl/keypad_poller.sv
// keypad_poller
//   Polls a keypad peripheral's status word every POLL_DIV idle cycles. When
//   the ready bit is set, it reads the data word, pushes the 4-bit key into a
//   small circular FIFO, and acknowledges the peripheral. The acknowledge is
//   repeated until the peripheral drops ready. If the FIFO is full and the
//   consumer is not popping in the same cycle, the key is dropped and a
//   sticky overflow flag is set.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   keypad_poller_if.master (peripheral + consumer signals)
//
//   Parameters:
//     POLL_DIV    idle cycles between status polls (>= 1)
//     FIFO_DEPTH  key FIFO entries, power of two, 2..16
module keypad_poller #(
  parameter int POLL_DIV   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  keypad_poller_if.master        bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STAT,
    S_RD_DATA,
    S_ACK,
    S_CHK
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sod_q, sod_d;
  logic          ack_q, ack_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [FIFO_DEPTH];

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_en;
  logic          push_en;
  logic          drop_key;

  // Only the low nibble of the data word and bit 0 of the status word matter.
  logic unused_keyout_hi;
  assign unused_keyout_hi = &{1'b0, bus.keyout[15:4]};

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  // A pop on an empty FIFO is simply ignored.
  assign pop_en     = bus.key_pop && !fifo_empty;

  // --------------------------------------------------------------------------
  // Poll FSM: next state, poll timer, push/drop decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    push_en  = 1'b0;
    drop_key = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // enable only gates leaving IDLE. A transaction already under way
        // always runs to completion.
        if (bus.enable) begin
          if (timer_q == TIMER_LAST) begin
            state_d = S_RD_STAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          timer_d = '0;
        end
      end

      S_RD_STAT: begin
        state_d = bus.keyout[0] ? S_RD_DATA : S_IDLE;
      end

      S_RD_DATA: begin
        // When the FIFO is full, a same-cycle pop frees the slot being
        // written, so the key still fits and count stays unchanged.
        if (!fifo_full || pop_en) begin
          push_en = 1'b1;
        end else begin
          drop_key = 1'b1;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        state_d = S_CHK;
      end

      S_CHK: begin
        // A still-set ready means the ack was missed: re-acknowledge it
        // without pushing the key a second time.
        state_d = bus.keyout[0] ? S_ACK : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are Moore-decoded from the next state so that they line up
    // with the state register.
    sod_d = (state_d != S_RD_DATA);
    ack_d = (state_d == S_ACK);
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, occupancy and overflow flag
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop_key) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      sod_q      <= 1'b1;
      ack_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sod_q      <= sod_d;
      ack_q      <= ack_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Key storage. It has no reset: resetting the pointers and count discards
  // the contents.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= bus.keyout[3:0];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.statusordata = sod_q;
  assign bus.ack          = ack_q;
  assign bus.count        = count_q;
  assign bus.key_valid    = !fifo_empty;
  assign bus.key_data     = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
  assign bus.overflow     = overflow_q;

endmodule

// File: doc/keypad_poller.md
# keypad_poller

Polling controller that sits between the CPU-side consumer and the keypad peripheral's status/data register port. It periodically reads the peripheral's status word and, when a key is ready, reads the data word. It then acknowledges the peripheral and pushes the 4-bit key code into a small FIFO. Keys are buffered so a slow consumer loses none until the FIFO overflows.

## Interface

Parameters:
- POLL_DIV, 1024: clk cycles spent in IDLE between status polls; legal range ≥1.
- FIFO_DEPTH, 4: key FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = polling allowed; gates only the IDLE→RD_STAT transition.
- keyout  in  16  peripheral read word: status = {15'b0, ready}, data = {12'b0, key}.
- statusordata  out  1  peripheral select: 1 = status word, 0 = data word.
- ack  out  1  peripheral acknowledge; clears the peripheral's ready bit.
- key_data  out  4  FIFO head entry; 4'h0 when the FIFO is empty.
- key_valid  out  1  FIFO non-empty.
- key_pop  in  1  consumer pop; removes the head at the clock edge when key_valid=1, ignored when empty.
- count  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
- overflow  out  1  sticky flag: a key was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow; a set in the same cycle wins.

## Operation

- Reset values: state IDLE, poll timer 0, FIFO empty (count 0, key_valid 0, key_data 0), statusordata 1, ack 0, overflow 0.
- statusordata is 1 in every state except RD_DATA. ack is 1 only in ACK. Both are registered, Moore-decoded outputs.
- FSM:
  - IDLE: timer increments each cycle while enable=1 and is held at 0 while enable=0. When enable=1 and timer==POLL_DIV-1: go to RD_STAT and clear timer.
  - RD_STAT: sample keyout[0]. If 1, go to RD_DATA. If 0, go to IDLE.
  - RD_DATA: statusordata=0; sample keyout[3:0] as the key code.
    - Not full: push the key.
    - Full and key_pop=1 this cycle: push and pop together; count unchanged; no overflow.
    - Full and key_pop=0: drop the key and set overflow.
    - Always go to ACK.
  - ACK: ack=1 for exactly one cycle, then go to CHK.
  - CHK: sample keyout[0]. If 0, go to IDLE. If 1, the peripheral has not cleared ready; go back to ACK and retry. No second push occurs.
- enable falling mid-transaction does not abort it; the FSM completes through CHK to IDLE, then stays in IDLE.
- FIFO behaviour:
  - Circular buffer with read/write pointers; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle when non-empty: count unchanged.
  - Pop when empty: no effect.
  - key_data always shows the entry at the read pointer.
- keyout[15:4] is ignored.

## Timing

- Poll period with no key pending: POLL_DIV cycles in IDLE + 1 RD_STAT cycle = POLL_DIV+1 cycles.
- Key latency, with ready=1 sampled in RD_STAT at cycle N:
  - RD_DATA at N+1; push at the end of N+1.
  - ACK at N+2, with key_valid=1 from N+2.
  - CHK at N+3; IDLE at N+4.
- Full service of one key: 4 cycles from RD_STAT to re-entering IDLE, with no retries.
- key_pop takes effect at the clock edge. count, key_valid and key_data update the following cycle.
- overflow sets at the end of the RD_DATA cycle that drops a key.
- rst asserted in any state forces the reset values immediately, asynchronously. FIFO contents are discarded. The first poll after reset release occurs after POLL_DIV IDLE cycles.

## Test plan

- Reset and idle: POLL_DIV=4, enable=1, ready=0 → statusordata stays 1, ack never asserts, RD_STAT entered every 5 cycles, key_valid=0.
- Single key: ready=1, data=4'h7 → statusordata=0 for exactly 1 cycle. Next cycle ack=1 for 1 cycle. key_valid=1 with key_data=4'h7, count=1. The peripheral model drops ready, and the FSM returns to IDLE 4 cycles after RD_STAT.
- Fill and overflow: FIFO_DEPTH=4; deliver keys 1,2,3,4,5 with no pops → count=4, overflow=1. Pops then return 1,2,3,4 and key 5 is lost. Assert ovf_clr → overflow=0.
- Push+pop when full: FIFO holds 4 keys; key_pop=1 in the same cycle as the RD_DATA push of key 4'hA → count stays 4, overflow=0, 4'hA is the last entry out.
- Ack retry: the peripheral model ignores the first ack (ready stays 1) → FSM performs ACK, CHK, ACK, CHK, then IDLE. Only one FIFO push occurs.
- Async reset mid-transaction: assert rst during ACK with 2 keys buffered → ack=0, statusordata=1, count=0, overflow=0 immediately. Normal polling resumes after release.
